// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared constants for the RV32I control sequencer.
//   ALU op codes, opcode/funct field values, sequencer state enum and a
//   small helper that maps an ALU funct3 onto the datapath op code.
package riscv_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_LOAD2} state_e;

  // funct3 values the ALU subset supports (ADD/SLT/OR/AND families)
  function automatic logic f3_alu_ok(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
  endfunction

  function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      F3_SLT:  op = ALU_SLT;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_ctrl_seq_if.sv
// riscv_ctrl_seq_if: instruction handshake plus the control outputs that
// steer RegFileALUMemory.
//   slave  : sequencer side (consumes instr/instr_valid, drives the rest)
//   master : instruction source / observer side
interface riscv_ctrl_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int PC_WIDTH   = 16
);
  logic [31:0]           instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [PC_WIDTH-1:0]   pc;
  logic [NAME_BITS-1:0]  rs1;
  logic [NAME_BITS-1:0]  rs2;
  logic [NAME_BITS-1:0]  ws_in;
  logic [CTRL_BITS-1:0]  op_in;
  logic                  imm_e;
  logic [DATA_WIDTH-1:0] imm_d;
  logic                  mem_rst;
  logic                  mem_we;
  logic                  mem_re;
  logic                  mem_rs;
  logic                  mem_ws;
  logic                  illegal;
  logic [15:0]           retired;

  modport slave (
    input  instr, instr_valid,
    output instr_ready, pc, rs1, rs2, ws_in, op_in, imm_e, imm_d,
           mem_rst, mem_we, mem_re, mem_rs, mem_ws, illegal, retired
  );

  modport master (
    output instr, instr_valid,
    input  instr_ready, pc, rs1, rs2, ws_in, op_in, imm_e, imm_d,
           mem_rst, mem_we, mem_re, mem_rs, mem_ws, illegal, retired
  );
endinterface

// File: rtl/riscv_decode.sv
// riscv_decode: purely combinational RV32I subset decoder.
//   instr in; control fields out plus legal flag. Unsupported encodings
//   report legal=0 and NOP fields.
module riscv_decode
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4
) (
  input  logic [31:0]           instr,
  output logic                  legal,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic                  mem_rs,
  output logic                  mem_ws
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [DATA_WIDTH-1:0] i_imm, s_imm;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign i_imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};

  always_comb begin
    legal  = 1'b0;
    rs1    = '0;
    rs2    = '0;
    ws     = '0;
    op     = CTRL_BITS'(ALU_ADD);
    imm_e  = 1'b0;
    imm_d  = '0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_rs = 1'b0;
    mem_ws = 1'b0;
    case (opc)
      OPC_R: begin
        // SUB is the only funct7 variant; everything else needs funct7=0
        if (f3_alu_ok(f3) && (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_ADD))) begin
          legal = 1'b1;
          rs1   = NAME_BITS'(instr[19:15]);
          rs2   = NAME_BITS'(instr[24:20]);
          ws    = NAME_BITS'(instr[11:7]);
          op    = (f7 == F7_ALT) ? CTRL_BITS'(ALU_SUB) : CTRL_BITS'(alu_of_f3(f3));
        end
      end
      OPC_I: begin
        if (f3_alu_ok(f3)) begin
          legal = 1'b1;
          rs1   = NAME_BITS'(instr[19:15]);
          ws    = NAME_BITS'(instr[11:7]);
          op    = CTRL_BITS'(alu_of_f3(f3));
          imm_e = 1'b1;
          imm_d = i_imm;
        end
      end
      OPC_LOAD: begin
        if (f3 == F3_W) begin
          legal  = 1'b1;
          rs1    = NAME_BITS'(instr[19:15]);
          ws     = NAME_BITS'(instr[11:7]);
          imm_e  = 1'b1;
          imm_d  = i_imm;
          mem_re = 1'b1;
          mem_rs = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_W) begin
          legal  = 1'b1;
          rs1    = NAME_BITS'(instr[19:15]);
          rs2    = NAME_BITS'(instr[24:20]);
          imm_e  = 1'b1;
          imm_d  = s_imm;
          mem_we = 1'b1;
          mem_ws = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/riscv_ctrl_seq.sv
// riscv_ctrl_seq: multicycle control sequencer for RegFileALUMemory.
//   clk, rst (async active-low) plain ports; everything else on bus:
//   instr/instr_valid/instr_ready handshake, pc, register names, ALU op,
//   immediate, memory strobes, illegal pulse and retired count.
//   All outputs are registered; IDLE drives a NOP (ADD, no write, no mem).
module riscv_ctrl_seq
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int PC_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  riscv_ctrl_seq_if.slave  bus
);
  logic                  dec_legal;
  logic [NAME_BITS-1:0]  dec_rs1, dec_rs2, dec_ws;
  logic [CTRL_BITS-1:0]  dec_op;
  logic                  dec_imm_e, dec_we, dec_re, dec_rs, dec_wsm;
  logic [DATA_WIDTH-1:0] dec_imm;

  riscv_decode #(
    .DATA_WIDTH(DATA_WIDTH), .NAME_BITS(NAME_BITS), .CTRL_BITS(CTRL_BITS)
  ) u_dec (
    .instr (bus.instr),
    .legal (dec_legal),
    .rs1   (dec_rs1),
    .rs2   (dec_rs2),
    .ws    (dec_ws),
    .op    (dec_op),
    .imm_e (dec_imm_e),
    .imm_d (dec_imm),
    .mem_we(dec_we),
    .mem_re(dec_re),
    .mem_rs(dec_rs),
    .mem_ws(dec_wsm)
  );

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [15:0]           ret_q, ret_d;
  logic                  rdy_q, rdy_d;
  logic                  ill_q, ill_d;
  logic                  mrst_q, mrst_d;
  logic [NAME_BITS-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, ws_q, ws_d;
  logic [CTRL_BITS-1:0]  op_q, op_d;
  logic                  imm_e_q, imm_e_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic                  we_q, we_d, re_q, re_d, rs_q, rs_d, wsm_q, wsm_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    rdy_d   = rdy_q;
    ill_d   = 1'b0;
    mrst_d  = 1'b0;   // memory reset only spans reset plus the first edge
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    ws_d    = ws_q;
    op_d    = op_q;
    imm_e_d = imm_e_q;
    imm_d   = imm_q;
    we_d    = we_q;
    re_d    = re_q;
    rs_d    = rs_q;
    wsm_d   = wsm_q;

    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          pc_d = pc_q + PC_WIDTH'(4);
          if (dec_legal) begin
            state_d = S_EXEC;
            rdy_d   = 1'b0;
            rs1_d   = dec_rs1;
            rs2_d   = dec_rs2;
            ws_d    = dec_ws;
            op_d    = dec_op;
            imm_e_d = dec_imm_e;
            imm_d   = dec_imm;
            we_d    = dec_we;
            re_d    = dec_re;
            rs_d    = dec_rs;
            wsm_d   = dec_wsm;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      default: begin
        // re_q marks LW, which needs one extra cycle with fields held
        if (state_q == S_EXEC && re_q) begin
          state_d = S_LOAD2;
        end else begin
          state_d = S_IDLE;
          rdy_d   = 1'b1;
          ret_d   = ret_q + 16'd1;
          rs1_d   = '0;
          rs2_d   = '0;
          ws_d    = '0;
          op_d    = CTRL_BITS'(ALU_ADD);
          imm_e_d = 1'b0;
          imm_d   = '0;
          we_d    = 1'b0;
          re_d    = 1'b0;
          rs_d    = 1'b0;
          wsm_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      rdy_q   <= 1'b1;
      ill_q   <= 1'b0;
      mrst_q  <= 1'b1;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ws_q    <= '0;
      op_q    <= CTRL_BITS'(ALU_ADD);
      imm_e_q <= 1'b0;
      imm_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rs_q    <= 1'b0;
      wsm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      rdy_q   <= rdy_d;
      ill_q   <= ill_d;
      mrst_q  <= mrst_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      ws_q    <= ws_d;
      op_q    <= op_d;
      imm_e_q <= imm_e_d;
      imm_q   <= imm_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rs_q    <= rs_d;
      wsm_q   <= wsm_d;
    end
  end

  assign bus.instr_ready = rdy_q;
  assign bus.pc          = pc_q;
  assign bus.retired     = ret_q;
  assign bus.illegal     = ill_q;
  assign bus.mem_rst     = mrst_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.ws_in       = ws_q;
  assign bus.op_in       = op_q;
  assign bus.imm_e       = imm_e_q;
  assign bus.imm_d       = imm_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_re      = re_q;
  assign bus.mem_rs      = rs_q;
  assign bus.mem_ws      = wsm_q;
endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// tb_riscv_ctrl_seq: directed test-plan sequence, asynchronous reset during
// EXEC/LOAD2, randomized instruction stream and a pc wrap run, all checked
// against a transaction-level reference model.
module tb_riscv_ctrl_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscv_ctrl_seq_if bus ();

  riscv_ctrl_seq dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ws;
    logic [3:0]  op;
    logic        imm_e;
    logic [31:0] imm;
    logic        we, re, rs, wsm;
  } fld_t;

  localparam fld_t NOP = '{rs1: 5'd0, rs2: 5'd0, ws: 5'd0, op: 4'b0010, imm_e: 1'b0,
                           imm: 32'd0, we: 1'b0, re: 1'b0, rs: 1'b0, wsm: 1'b0};

  int errs   = 0;
  int checks = 0;

  // model state: cycles the current instruction still occupies, its fields
  int          busy;
  fld_t        ef;
  logic [15:0] epc, eret;
  logic        eill, emrst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level decode: which mnemonic, then what the datapath should see.
  function automatic void ref_decode(input logic [31:0] w, output logic ok,
                                     output int cycles, output fld_t f);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int code;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    f = NOP; ok = 1'b0; cycles = 1; code = -1;
    if (opc == 7'b0110011) begin
      case ({f7, f3})
        10'b0000000_000: code = 2;   // ADD
        10'b0100000_000: code = 6;   // SUB
        10'b0000000_010: code = 7;   // SLT
        10'b0000000_110: code = 1;   // OR
        10'b0000000_111: code = 0;   // AND
        default: code = -1;
      endcase
      if (code >= 0) begin
        ok = 1'b1; f.op = 4'(code);
        f.rs1 = w[19:15]; f.rs2 = w[24:20]; f.ws = w[11:7];
      end
    end else if (opc == 7'b0010011) begin
      case (f3)
        3'b000: code = 2;
        3'b010: code = 7;
        3'b110: code = 1;
        3'b111: code = 0;
        default: code = -1;
      endcase
      if (code >= 0) begin
        ok = 1'b1; f.op = 4'(code); f.rs1 = w[19:15]; f.ws = w[11:7];
        f.imm_e = 1'b1; f.imm = 32'($signed(w[31:20]));
      end
    end else if (opc == 7'b0000011 && f3 == 3'b010) begin
      ok = 1'b1; cycles = 2; f.rs1 = w[19:15]; f.ws = w[11:7];
      f.imm_e = 1'b1; f.imm = 32'($signed(w[31:20])); f.re = 1'b1; f.rs = 1'b1;
    end else if (opc == 7'b0100011 && f3 == 3'b010) begin
      ok = 1'b1; f.rs1 = w[19:15]; f.rs2 = w[24:20];
      f.imm_e = 1'b1; f.imm = 32'($signed({w[31:25], w[11:7]})); f.we = 1'b1; f.wsm = 1'b1;
    end
  endfunction

  task automatic model_reset();
    busy = 0; ef = NOP; epc = '0; eret = '0; eill = 1'b0; emrst = 1'b1;
  endtask

  // one clock edge as seen by the model, using the inputs present at it
  task automatic model_tick();
    logic ok; int cyc; fld_t f;
    eill = 1'b0; emrst = 1'b0;
    if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        eret++;
        ef = NOP;
      end
    end else if (bus.instr_valid) begin
      epc += 16'd4;
      ref_decode(bus.instr, ok, cyc, f);
      if (ok) begin
        ef = f; busy = cyc;
      end else begin
        eill = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    fld_t got;
    got = {bus.rs1, bus.rs2, bus.ws_in, bus.op_in, bus.imm_e, bus.imm_d,
           bus.mem_we, bus.mem_re, bus.mem_rs, bus.mem_ws};
    chk("ready", 64'(bus.instr_ready), 64'(busy == 0));
    chk("pc", 64'(bus.pc), 64'(epc));
    chk("retired", 64'(bus.retired), 64'(eret));
    chk("illegal", 64'(bus.illegal), 64'(eill));
    chk("mem_rst", 64'(bus.mem_rst), 64'(emrst));
    chk("fields", 64'(got), 64'(ef));
  endtask

  task automatic step(input logic v, input logic [31:0] w);
    @(negedge clk);
    bus.instr_valid = v;
    bus.instr       = w;
    @(posedge clk);
    model_tick();
    #1;
    check_all();
  endtask

  // asserts reset away from any edge, checks the asynchronous effect,
  // holds it across one edge, then releases it before the next edge
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    bus.instr_valid = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all();   // mem_rst still high until the next edge
  endtask

  function automatic logic [31:0] gen_instr();
    logic [2:0] f3s [4];
    logic [31:0] r;
    logic [4:0] a, b, d;
    int sel;
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
    r = $urandom; a = 5'($urandom); b = 5'($urandom); d = 5'($urandom);
    sel = int'($urandom_range(0, 5));
    case (sel)
      0: gen_instr = {($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0000000, b, a,
                      f3s[$urandom_range(0, 3)], d, 7'b0110011};
      1: gen_instr = {r[31:20], a, f3s[$urandom_range(0, 3)], d, 7'b0010011};
      2: gen_instr = {r[31:20], a, 3'b010, d, 7'b0000011};
      3: gen_instr = {r[31:25], b, a, 3'b010, r[11:7], 7'b0100011};
      4: gen_instr = r;
      default: begin
        // a supported opcode with random funct bits, mostly unsupported
        case ($urandom_range(0, 3))
          0: gen_instr = {r[31:7], 7'b0110011};
          1: gen_instr = {r[31:7], 7'b0010011};
          2: gen_instr = {r[31:7], 7'b0000011};
          default: gen_instr = {r[31:7], 7'b0100011};
        endcase
      end
    endcase
  endfunction

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    model_reset();
    #12 check_all();
    #5 rst = 1'b1;
    #1 check_all();

    // test-plan sequence
    step(1'b1, 32'h00500093);                  // ADDI x1,x0,5
    step(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h40300233);  // SUB held valid
    step(1'b0, 32'h0);
    step(1'b1, 32'hFFC0A283);                  // LW x5,-4(x1)
    step(1'b1, 32'h0020A423);                  // ignored while busy
    step(1'b1, 32'h0020A423);                  // ignored while busy
    step(1'b1, 32'h0020A423);                  // SW x2,8(x1)
    step(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFFFFFF);  // illegal each cycle
    step(1'b0, 32'h0);

    // reset mid-LOAD2 and mid-EXEC of a store
    step(1'b1, 32'hFFC0A283);
    step(1'b0, 32'h0);
    do_reset();
    step(1'b1, 32'h0020A423);
    do_reset();

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) < 7), gen_instr());

    // stream of illegal words to wrap the 16-bit pc
    for (int i = 0; i < 16400; i++) step(1'b1, 32'hFFFFFFFF);
    step(1'b1, 32'h00500093);
    step(1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/riscv_ctrl_seq.md
# riscv_ctrl_seq

Multicycle control sequencer that drives the control side of `RegFileALUMemory`: `rs1`, `rs2`, `ws_in`, `op_in`, `imm_e`, `imm_d` and the memory strobes. It accepts 32-bit RV32I instructions over a valid/ready handshake, decodes a subset (R/I-type ALU, LW, SW) and holds each instruction's control fields stable for the cycles the datapath needs. It also keeps the program counter and a retired-instruction count.

## Interface
- DATA_WIDTH, 32, immediate/data width
- NAME_BITS, 5, register-name width
- CTRL_BITS, 4, ALU op width
- PC_WIDTH, 16, program-counter width
- clk  input  1  single clock, all state on posedge
- rst  input  1  asynchronous, active-low reset
- instr  input  32  instruction word
- instr_valid  input  1  instr is present
- instr_ready  output  1  sequencer can accept
- pc  output  PC_WIDTH  address of next instruction to fetch
- rs1, rs2  output  NAME_BITS  source register names
- ws_in  output  NAME_BITS  destination register (0 = no write)
- op_in  output  CTRL_BITS  ALU op
- imm_e  output  1  select imm_d as ALU operand b
- imm_d  output  DATA_WIDTH  sign-extended immediate
- mem_rst, mem_we, mem_re, mem_rs, mem_ws  output  1  memory controls
- illegal  output  1  one-cycle pulse on unsupported instruction
- retired  output  16  count of retired instructions

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- Opcode 0110011 (R): funct3 000 + funct7 0000000 ADD, 0100000 SUB; 010 SLT; 110 OR; 111 AND. Fields: rs1=instr[19:15], rs2=instr[24:20], ws_in=instr[11:7], imm_e=0.
- Opcode 0010011 (I): funct3 000 ADDI, 010 SLTI, 110 ORI, 111 ANDI. imm_e=1, imm_d=sext(instr[31:20]), rs2=0.
- Opcode 0000011, funct3 010 (LW): op ADD, imm_e=1, I-imm, mem_re=1, mem_rs=1, ws_in=rd.
- Opcode 0100011, funct3 010 (SW): op ADD, imm_e=1, imm_d=sext({instr[31:25],instr[11:7]}), rs2=instr[24:20], mem_we=1, mem_ws=1, ws_in=0.
- Any other encoding: illegal pulse, no datapath activity, pc still advances by 4, retired unchanged.
- FSM states: IDLE, EXEC, LOAD2.
  - IDLE: instr_ready=1; on valid&ready latch decoded fields, go to EXEC (or stay in IDLE and pulse illegal if unsupported).
  - EXEC: fields driven; LW goes to LOAD2, others go to IDLE and retire.
  - LOAD2: fields held unchanged, mem_re still 1; go to IDLE and retire.
- In IDLE all datapath outputs are NOP: rs1=rs2=ws_in=0, op ADD, imm_e=0, imm_d=0, all mem strobes 0.
- pc advances by 4 on every accept, wrapping modulo 2^PC_WIDTH. retired advances by 1 on leaving EXEC (non-LW) or LOAD2, wrapping at 16 bits.
- ws_in=0 means discard. Register r0 is never written by contract.

## Timing
- Reset (rst low, asynchronous): state IDLE, pc=0, retired=0, illegal=0, all datapath outputs NOP, mem_rst=1. mem_rst clears on the first posedge after rst rises.
- Accept at edge N: fields valid from edge N through edge N+1 (ALU/SW) or N+2 (LW). instr_ready returns high after that.
- Throughput: one instruction per 2 cycles (ALU/SW), per 3 cycles (LW), per 1 cycle (illegal).
- instr_ready is a registered output that depends only on state. instr is ignored when ready=0.
- Reset asserted mid-EXEC/LOAD2: instruction is abandoned and not retired; mem_we drops asynchronously.

## Structure
- Package `riscv_ctrl_pkg`: ALU op constants, opcode/funct constants, state enum.
- Sub-module `riscv_decode`: purely combinational, maps instr to control fields plus a legal flag. The sequencer registers its outputs.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093) -> EXEC: rs1=0, ws_in=1, op 0010, imm_e=1, imm_d=5; pc=4; retired=1.
- SUB x4,x0,x3 (0x40300233) -> op 0110, rs2=3, ws_in=4, imm_e=0; back-to-back valid accepted every 2nd cycle.
- LW x5,-4(x1) (0xFFC0A283) -> imm_d=0xFFFFFFFC, mem_re=1 and mem_rs=1 for 2 cycles; ready low 2 cycles.
- SW x2,8(x1) (0x0020A423) -> imm_d=8, mem_we=1, ws_in=0, rs2=2, single cycle.
- Illegal 0xFFFFFFFF -> illegal pulse 1 cycle, NOP outputs, pc+=4, retired unchanged.
- rst low mid-LW -> immediate NOP outputs, pc=0, retired=0, mem_rst=1 until first edge after release.
